// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, constants and frame helpers
package uart_pkg;

   // Parity selector encoding; both 00 and 11 mean "no parity bit"
   localparam logic [1:0] PARITY_NONE     = 2'b00;
   localparam logic [1:0] PARITY_EVEN     = 2'b01;
   localparam logic [1:0] PARITY_ODD      = 2'b10;
   localparam logic [1:0] PARITY_NONE_ALT = 2'b11;

   // Divider used before any frame has latched a real one (115200 baud at 50 MHz)
   localparam int unsigned DEFAULT_DIVIDER = 434;

   typedef enum logic [2:0] {
      ST_HOLDOFF,
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP1,
      ST_STOP2
   } tx_state_e;

   function automatic logic parity_enabled(input logic [1:0] parity);
      return (parity != PARITY_NONE) && (parity != PARITY_NONE_ALT);
   endfunction

   // Parity bit from the XOR of the transmitted data bits
   function automatic logic parity_bit(input logic data_xor, input logic [1:0] parity);
      logic result;
      case (parity)
         PARITY_EVEN: result = data_xor;
         PARITY_ODD:  result = ~data_xor;
         default:     result = 1'b0;
      endcase
      return result;
   endfunction

   // Bits per frame: start + data + optional parity + one or two stops
   function automatic logic [3:0] frame_bits(input logic [3:0] data_bits,
                                             input logic       parity_en,
                                             input logic       two_stop);
      return 4'd2 + data_bits + {3'b000, parity_en} + {3'b000, two_stop};
   endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - first-word-fall-through write FIFO for the UART transmitter
module uart_tx_fifo #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 4
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] push_data,
   input  logic                  pop,
   output logic [DATA_WIDTH-1:0] pop_data,
   output logic                  full,
   output logic                  empty
);

   localparam int AW = $clog2(DEPTH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]         wr_ptr;
   logic [AW-1:0]         rd_ptr;
   logic [AW:0]           count;
   logic                  do_push;
   logic                  do_pop;

   // A push into a full FIFO is only legal when a pop frees a slot in the same cycle
   assign do_push  = push & (~full | pop);
   assign do_pop   = pop & ~empty;
   assign pop_data = mem[rd_ptr];
   assign full     = (count == (AW+1)'(DEPTH));
   assign empty    = (count == '0);

   // Pointer and occupancy tracking
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage array; contents are don't-care until written
   always_ff @(posedge clock) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

endmodule

// File: rtl/uart_tx_framed.sv
// rtl/uart_tx_framed.sv - framed UART transmitter with write FIFO and runtime frame format
module uart_tx_framed
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH    = 8,
   parameter int FIFO_DEPTH    = 4,
   parameter int DIVIDER_WIDTH = 16
) (
   input  logic                     clock_i,
   input  logic                     reset_i,
   input  logic [DIVIDER_WIDTH-1:0] clock_divider_i,
   input  logic [3:0]               data_bits_i,
   input  logic [1:0]               parity_i,
   input  logic                     stop_bits_i,
   input  logic                     write_i,
   input  logic [DATA_WIDTH-1:0]    data_i,
   output logic                     serial_o,
   output logic                     busy_o,
   output logic                     idle_o,
   output logic                     overflow_o
);

   // Wide enough for (max frame bits) x (max divider + 1)
   localparam int HW = DIVIDER_WIDTH + 5;

   tx_state_e               state;
   tx_state_e               state_d;
   logic                    write_q;
   logic                    write_rise;
   logic                    push;
   logic                    load;
   logic                    fifo_full;
   logic                    fifo_empty;
   logic [DATA_WIDTH-1:0]   fifo_rdata;
   logic [3:0]              bits_eff;
   logic                    par_en_in;
   logic [DATA_WIDTH-1:0]   data_mask;
   logic                    par_calc;
   logic [DIVIDER_WIDTH-1:0] cfg_div;
   logic [DIVIDER_WIDTH-1:0] baud_cnt;
   logic [3:0]              cfg_bits;
   logic [3:0]              bit_idx;
   logic                    cfg_par_en;
   logic                    cfg_two_stop;
   logic [DATA_WIDTH-1:0]   shift_q;
   logic [DATA_WIDTH-1:0]   shift_d;
   logic                    par_q;
   logic                    par_d;
   logic                    serial_q;
   logic                    line_d;
   logic                    overflow_q;
   logic                    hold_init;
   logic [HW-1:0]           hold_cnt;
   logic [HW-1:0]           holdoff_len;
   logic                    bit_done;
   logic                    data_last;

   // Out-of-range data lengths fall back to the full data width
   assign bits_eff  = (data_bits_i < 4'd5 || data_bits_i > 4'(DATA_WIDTH)) ?
                      4'(DATA_WIDTH) : data_bits_i;
   assign par_en_in = parity_enabled(parity_i);
   assign data_mask = ~({DATA_WIDTH{1'b1}} << bits_eff);
   assign par_calc  = parity_bit(^(fifo_rdata & data_mask), parity_i);

   assign holdoff_len = HW'(frame_bits(bits_eff, par_en_in, stop_bits_i)) *
                        (HW'(clock_divider_i) + HW'(1));

   // The edge register resets to 1 so a write held through reset never fires
   assign write_rise = write_i & ~write_q;
   assign push       = write_rise & ~busy_o;

   assign bit_done  = (baud_cnt == '0);
   assign data_last = (bit_idx == cfg_bits - 4'd1);

   assign busy_o     = (state == ST_HOLDOFF) | fifo_full;
   assign idle_o     = (state == ST_IDLE) & fifo_empty;
   assign serial_o   = serial_q;
   assign overflow_o = overflow_q;

   uart_tx_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (FIFO_DEPTH)
   ) u_fifo (
      .clock     (clock_i),
      .reset     (reset_i),
      .push      (push),
      .push_data (data_i),
      .pop       (load),
      .pop_data  (fifo_rdata),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // State register, registered line driver and write edge detector
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state      <= ST_HOLDOFF;
         serial_q   <= 1'b1;
         write_q    <= 1'b1;
         overflow_q <= 1'b0;
         shift_q    <= '0;
         par_q      <= 1'b0;
      end else begin
         state      <= state_d;
         serial_q   <= line_d;
         write_q    <= write_i;
         overflow_q <= write_rise & busy_o;
         shift_q    <= shift_d;
         par_q      <= par_d;
      end
   end

   // Bit timing and per-frame configuration latched when a frame loads
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         baud_cnt     <= '0;
         bit_idx      <= '0;
         cfg_div      <= DIVIDER_WIDTH'(DEFAULT_DIVIDER);
         cfg_bits     <= 4'(DATA_WIDTH);
         cfg_par_en   <= 1'b0;
         cfg_two_stop <= 1'b0;
      end else if (load) begin
         baud_cnt     <= clock_divider_i;
         bit_idx      <= '0;
         cfg_div      <= clock_divider_i;
         cfg_bits     <= bits_eff;
         cfg_par_en   <= par_en_in;
         cfg_two_stop <= stop_bits_i;
      end else if (state inside {ST_START, ST_DATA, ST_PARITY, ST_STOP1, ST_STOP2}) begin
         baud_cnt <= bit_done ? cfg_div : baud_cnt - DIVIDER_WIDTH'(1);
         if (state == ST_DATA && bit_done) begin
            bit_idx <= bit_idx + 4'd1;
         end
      end
   end

   // Hold-off length is taken from the configuration on the first cycle after reset
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         hold_init <= 1'b1;
         hold_cnt  <= '0;
      end else if (state == ST_HOLDOFF) begin
         if (hold_init) begin
            hold_cnt  <= holdoff_len - HW'(2);
            hold_init <= 1'b0;
         end else if (hold_cnt != '0) begin
            hold_cnt <= hold_cnt - HW'(1);
         end
      end
   end

   // Next-state logic; a finishing stop bit reloads straight into START when data is queued
   always_comb begin
      state_d = state;
      load    = 1'b0;
      case (state)
         ST_HOLDOFF: begin
            if (!hold_init && hold_cnt == '0) begin
               state_d = ST_IDLE;
            end
         end
         ST_IDLE: begin
            if (!fifo_empty) begin
               load    = 1'b1;
               state_d = ST_START;
            end
         end
         ST_START: begin
            if (bit_done) begin
               state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            if (bit_done && data_last) begin
               state_d = cfg_par_en ? ST_PARITY : ST_STOP1;
            end
         end
         ST_PARITY: begin
            if (bit_done) begin
               state_d = ST_STOP1;
            end
         end
         ST_STOP1: begin
            if (bit_done) begin
               if (cfg_two_stop) begin
                  state_d = ST_STOP2;
               end else if (!fifo_empty) begin
                  load    = 1'b1;
                  state_d = ST_START;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         ST_STOP2: begin
            if (bit_done) begin
               if (!fifo_empty) begin
                  load    = 1'b1;
                  state_d = ST_START;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_HOLDOFF;
      endcase
   end

   // Shifter, parity and the line level for the coming cycle
   always_comb begin
      shift_d = shift_q;
      par_d   = par_q;
      line_d  = 1'b1;
      if (load) begin
         shift_d = fifo_rdata;
         par_d   = par_calc;
      end else if (state == ST_DATA && bit_done) begin
         shift_d = shift_q >> 1;
      end
      case (state_d)
         ST_START:  line_d = 1'b0;
         ST_DATA:   line_d = shift_d[0];
         ST_PARITY: line_d = par_d;
         default:   line_d = 1'b1;
      endcase
   end

endmodule
